// File: rtl/bf_lut_bank.sv
// bf_lut_bank: writable bank of bandwidth-factor lookup tables.
// Self-initialises every bank to the default profile after reset or on
// init_req. Entry 0 of each bank gets ZERO_VAL and every other entry gets
// FILL_VAL. In RUN it serves pipelined reads and accepts run-time
// coefficient writes.
//
// Read path: a request is captured at edge k. The array is read at edge k+1
// (read-first). Bfp/Bfp_vld are updated at edge k+2. Writes are captured at
// edge k and committed to the array at edge k+1. This means:
//   - a read sampled on the same edge as a write returns the old entry;
//   - a read sampled one edge later returns the new entry.

`default_nettype none

module bf_lut_bank #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_BANK = 2,
    parameter int FILL_VAL = 2,
    parameter int ZERO_VAL = 0,
    localparam int BW      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic              CS,
    input  logic              cen,
    input  logic              init_req,
    output logic              busy,
    input  logic              rd_req,
    input  logic [BW-1:0]     rd_bank,
    input  logic [ADDR_W-1:0] add,
    output logic              rd_rdy,
    output logic [DATA_W-1:0] Bfp,
    output logic              Bfp_vld,
    input  logic              wr_en,
    input  logic [BW-1:0]     wr_bank,
    input  logic [ADDR_W-1:0] wr_add,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int ENTRIES = NUM_BANK * DEPTH;
    localparam int IW      = BW + ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True when a bank select addresses an existing table.
    function automatic logic bank_ok(input logic [BW-1:0] b);
        return ({1'b0, b} < (BW + 1)'(NUM_BANK));
    endfunction

    // Default profile value for a given entry of any bank.
    function automatic logic [DATA_W-1:0] default_val(input logic [ADDR_W-1:0] a);
        return (a == {ADDR_W{1'b0}}) ? DATA_W'(ZERO_VAL) : DATA_W'(FILL_VAL);
    endfunction

    // Storage. The flat index is bank*depth+entry. Because depth is a power
    // of two, this index is simply the concatenation {bank, entry}.
    logic [DATA_W-1:0] mem_r [ENTRIES];

    // Control state
    state_t              state_r;
    state_t              state_nx_s;
    logic [BW-1:0]       fill_bank_r;
    logic [BW-1:0]       fill_bank_nx_s;
    logic [ADDR_W-1:0]   fill_add_r;
    logic [ADDR_W-1:0]   fill_add_nx_s;
    logic                busy_r;
    logic                rd_rdy_r;

    // Fill write port signals
    logic                fill_we_s;
    logic                fill_last_s;
    logic [IW-1:0]       fill_idx_s;
    logic [DATA_W-1:0]   fill_val_s;

    // Captured write request
    logic                wr_ok_s;
    logic                wr_drop_s;
    logic                wq_vld_r;
    logic [BW-1:0]       wq_bank_r;
    logic [ADDR_W-1:0]   wq_add_r;
    logic [DATA_W-1:0]   wq_data_r;
    logic                wr_err_r;
    logic [IW-1:0]       wq_idx_s;

    // Read pipeline
    logic                rd_acc_s;
    logic                rq_vld_r;
    logic [BW-1:0]       rq_bank_r;
    logic [ADDR_W-1:0]   rq_add_r;
    logic                s1_vld_r;
    logic [DATA_W-1:0]   s1_data_r;
    logic [DATA_W-1:0]   bfp_r;
    logic                bfp_vld_r;

    assign fill_we_s   = (state_r == ST_INIT);
    assign fill_last_s = (fill_add_r == {ADDR_W{1'b1}}) &&
                         (fill_bank_r == BW'(NUM_BANK - 1));
    assign fill_idx_s  = {fill_bank_r, fill_add_r};
    assign fill_val_s  = default_val(fill_add_r);

    assign rd_acc_s  = rd_req & rd_rdy_r;
    assign wr_ok_s   = wr_en & (state_r == ST_RUN) & bank_ok(wr_bank);
    assign wr_drop_s = wr_en & ~((state_r == ST_RUN) & bank_ok(wr_bank));
    assign wq_idx_s  = {wq_bank_r, wq_add_r};

    assign busy    = busy_r;
    assign rd_rdy  = rd_rdy_r;
    assign Bfp     = bfp_r;
    assign Bfp_vld = bfp_vld_r;
    assign wr_err  = wr_err_r;

    // Next-state logic: walk the fill counter, leave INIT on the last index,
    // and restart the fill on init_req while running.
    always_comb begin
        state_nx_s     = state_r;
        fill_bank_nx_s = fill_bank_r;
        fill_add_nx_s  = fill_add_r;
        case (state_r)
            ST_INIT: begin
                if (fill_last_s) begin
                    state_nx_s     = ST_RUN;
                    fill_bank_nx_s = {BW{1'b0}};
                    fill_add_nx_s  = {ADDR_W{1'b0}};
                end else if (fill_add_r == {ADDR_W{1'b1}}) begin
                    fill_add_nx_s  = {ADDR_W{1'b0}};
                    fill_bank_nx_s = fill_bank_r + BW'(1'b1);
                end else begin
                    fill_add_nx_s  = fill_add_r + ADDR_W'(1'b1);
                end
            end
            ST_RUN: begin
                if (init_req) begin
                    state_nx_s     = ST_INIT;
                    fill_bank_nx_s = {BW{1'b0}};
                    fill_add_nx_s  = {ADDR_W{1'b0}};
                end else begin
                    state_nx_s     = ST_RUN;
                end
            end
            default: begin
                state_nx_s     = ST_INIT;
                fill_bank_nx_s = {BW{1'b0}};
                fill_add_nx_s  = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, fill counter and registered status outputs.
    always_ff @(posedge CS or posedge cen) begin
        if (cen) begin
            state_r     <= ST_INIT;
            fill_bank_r <= {BW{1'b0}};
            fill_add_r  <= {ADDR_W{1'b0}};
            busy_r      <= 1'b1;
            rd_rdy_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            fill_bank_r <= fill_bank_nx_s;
            fill_add_r  <= fill_add_nx_s;
            busy_r      <= (state_nx_s == ST_INIT);
            rd_rdy_r    <= (state_nx_s == ST_RUN);
        end
    end

    // Capture accepted writes for commit on the next edge, and flag dropped ones.
    always_ff @(posedge CS or posedge cen) begin
        if (cen) begin
            wq_vld_r  <= 1'b0;
            wq_bank_r <= {BW{1'b0}};
            wq_add_r  <= {ADDR_W{1'b0}};
            wq_data_r <= {DATA_W{1'b0}};
            wr_err_r  <= 1'b0;
        end else begin
            wq_vld_r  <= wr_ok_s;
            wq_bank_r <= wr_bank;
            wq_add_r  <= wr_add;
            wq_data_r <= wr_data;
            wr_err_r  <= wr_drop_s;
        end
    end

    // Single array write port. The fill owns the port while initialising.
    // Any write still pending at that point targets an entry that the fill
    // rewrites anyway.
    always_ff @(posedge CS) begin
        if (fill_we_s) begin
            mem_r[fill_idx_s] <= fill_val_s;
        end else if (wq_vld_r) begin
            mem_r[wq_idx_s] <= wq_data_r;
        end
    end

    // Read request capture.
    always_ff @(posedge CS or posedge cen) begin
        if (cen) begin
            rq_vld_r  <= 1'b0;
            rq_bank_r <= {BW{1'b0}};
            rq_add_r  <= {ADDR_W{1'b0}};
        end else begin
            rq_vld_r  <= rd_acc_s;
            rq_bank_r <= rd_bank;
            rq_add_r  <= add;
        end
    end

    // Stage 1: read-first array read. Out-of-range banks read as zero.
    always_ff @(posedge CS or posedge cen) begin
        if (cen) begin
            s1_vld_r  <= 1'b0;
            s1_data_r <= {DATA_W{1'b0}};
        end else begin
            s1_vld_r <= rq_vld_r;
            if (rq_vld_r) begin
                s1_data_r <= bank_ok(rq_bank_r) ? mem_r[{rq_bank_r, rq_add_r}]
                                                : {DATA_W{1'b0}};
            end else begin
                s1_data_r <= s1_data_r;
            end
        end
    end

    // Stage 2: output register. Bfp holds its value between reads.
    always_ff @(posedge CS or posedge cen) begin
        if (cen) begin
            bfp_r     <= {DATA_W{1'b0}};
            bfp_vld_r <= 1'b0;
        end else begin
            bfp_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                bfp_r <= s1_data_r;
            end else begin
                bfp_r <= bfp_r;
            end
        end
    end

endmodule

`default_nettype wire
